pipeline_hazard_sequencer: RTL
==============================

// Module: pipeline_hazard_sequencer
// PURPOSE
//  Sequences the ID/EX boundary of the 5-stage MIPS pipeline and drives the Execute stage's
//  inForwardingA/B and inHazard inputs. Detects load-use hazards, control flushes and
//  multi-cycle ALU ops. Produces PC/IF-ID write enables, a bubble flag and a stall-cycle
//  counter. Sits beside the forwarding muxes, fed by ID, EX, MEM and WB pipeline registers.
// PARAMETERS
//  MUL_LATENCY  4   EX cycles held by a multi-cycle op (mult/div); legal range 2..15
//  CNT_W        16  width of the stall-cycle performance counter
// PORTS
//  clock            in   1      rising-edge clock
//  reset            in   1      synchronous, active-high
//  ifidRs           in   5      rs of the instruction in ID
//  ifidRt           in   5      rt of the instruction in ID
//  idexRs           in   5      rs of the instruction in EX
//  idexRt           in   5      rt of the instruction in EX
//  idexMemRead      in   1      instruction in EX is a load
//  exmemRegWrite    in   1      MEM-stage instruction writes a register
//  exmemWr          in   5      MEM-stage destination register
//  memwbRegWrite    in   1      WB-stage instruction writes a register
//  memwbWr          in   5      WB-stage destination register
//  branchTaken      in   1      branch resolved taken in MEM (branch & zero)
//  mulStart         in   1      instruction entering EX is multi-cycle
//  outForwardingA   out  2      00 regA, 10 aluResult_MEMEXE, 01 outmux_WBEXE
//  outForwardingB   out  2      same encoding, for operand B
//  outHazard        out  1      1 = no hazard, 0 = insert bubble (zero EX control flags)
//  pcWrite          out  1      PC update enable
//  ifidWrite        out  1      IF/ID register write enable
//  flush            out  1      clear IF/ID and ID/EX
//  busy             out  1      multi-cycle op in progress
//  stallCycles      out  CNT_W  cycles with pcWrite=0 since reset, saturating
// BEHAVIOUR
//  - Reset: state RUN, count=0, stallCycles=0.
//  - Reset outputs: outHazard=1, pcWrite=1, ifidWrite=1, flush=0, busy=0.
//  - Forwarding is combinational and state-independent.
//  - A=10 if exmemRegWrite & exmemWr!=0 & exmemWr==idexRs.
//  - Otherwise A=01 if memwbRegWrite & memwbWr!=0 & memwbWr==idexRs.
//  - Otherwise A=00. B uses the same rules on idexRt. MEM beats WB when both match.
//  - loadUse = idexMemRead & idexRt!=0 & (idexRt==ifidRs | idexRt==ifidRt).
//  - State RUN, priority order (control outputs are same-cycle decode of state+inputs):
//    1) branchTaken: flush=1, outHazard=0, pcWrite=1; loadUse/mulStart ignored; stay RUN.
//    2) loadUse: pcWrite=0, ifidWrite=0, outHazard=0; stay RUN. Exactly one bubble,
//       since the load has moved to MEM on the next edge.
//    3) mulStart: count<=MUL_LATENCY-1, next state MULDIV; outputs as idle this cycle.
//    4) Otherwise idle outputs: pcWrite=1, ifidWrite=1, outHazard=1, flush=0.
//  - State MULDIV: busy=1, pcWrite=0, ifidWrite=0, outHazard=1. count decrements each
//    cycle. When count==1, next state is RUN (busy low the following cycle).
//    Total busy cycles = MUL_LATENCY-1; with the start cycle, EX is occupied MUL_LATENCY.
//  - branchTaken in MULDIV: flush=1 that cycle; the op still completes; count not disturbed.
//  - mulStart and loadUse are ignored while in MULDIV.
//  - stallCycles increments on every edge where pcWrite==0. Holds at all-ones; no wrap.
//  - Reset mid-MULDIV: return to RUN on that edge; busy and counters cleared.
// TESTING
//  1) Forwarding: exmemWr=idexRs=10, exmemRegWrite=1 -> A=10.
//     Same with memwbWr=10 also set -> A=10.
//     Only memwbWr=13=idexRt, memwbRegWrite=1 -> B=01. Wr=0 match -> 00.
//  2) Load-use: idexMemRead=1, idexRt=13, ifidRt=13 -> one cycle of pcWrite=0, ifidWrite=0,
//     outHazard=0. Next cycle (idexMemRead=0) all 1. stallCycles 0->1.
//  3) Multi-cycle op, MUL_LATENCY=4: mulStart pulse -> busy=1 and pcWrite=0 for exactly
//     3 cycles, then busy=0. stallCycles=3.
//  4) branchTaken with loadUse in the same cycle -> flush=1, pcWrite=1, outHazard=0.
//     No stall; stallCycles unchanged.
//  5) Reset asserted in 2nd MULDIV cycle -> next edge busy=0, pcWrite=1, stallCycles=0.
//     A following mulStart restarts the full 3-cycle busy window.
//  6) Force stallCycles near saturation (CNT_W=4 build), stall 20 cycles -> holds at 15.

Source files
------------

// File: rtl/pipeline_hazard_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_sequencer_if
// Brief    : ID/EX hazard-sequencer bundle. Pipeline-register fields in,
//            forwarding selects and stall/flush controls out.
// Revision : 1.0 - initial release
// ============================================================================
interface pipeline_hazard_sequencer_if #(
  parameter int CNT_W = 16
);
  // Register fields from the ID, EX, MEM and WB pipeline registers
  logic [4:0]       ifidRs;
  logic [4:0]       ifidRt;
  logic [4:0]       idexRs;
  logic [4:0]       idexRt;
  logic             idexMemRead;
  logic             exmemRegWrite;
  logic [4:0]       exmemWr;
  logic             memwbRegWrite;
  logic [4:0]       memwbWr;
  logic             branchTaken;
  logic             mulStart;

  // Controls back to the datapath
  logic [1:0]       outForwardingA;
  logic [1:0]       outForwardingB;
  logic             outHazard;
  logic             pcWrite;
  logic             ifidWrite;
  logic             flush;
  logic             busy;
  logic [CNT_W-1:0] stallCycles;

  // Pipeline side: supplies register fields, consumes controls
  modport master (
    output ifidRs, ifidRt, idexRs, idexRt, idexMemRead,
           exmemRegWrite, exmemWr, memwbRegWrite, memwbWr,
           branchTaken, mulStart,
    input  outForwardingA, outForwardingB, outHazard, pcWrite,
           ifidWrite, flush, busy, stallCycles
  );

  // Sequencer side
  modport slave (
    input  ifidRs, ifidRt, idexRs, idexRt, idexMemRead,
           exmemRegWrite, exmemWr, memwbRegWrite, memwbWr,
           branchTaken, mulStart,
    output outForwardingA, outForwardingB, outHazard, pcWrite,
           ifidWrite, flush, busy, stallCycles
  );
endinterface
`default_nettype wire

// File: rtl/pipeline_hazard_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_sequencer
// Brief    : ID/EX boundary sequencer for the 5-stage MIPS pipeline. Selects
//            operand forwarding, inserts load-use bubbles, flushes on taken
//            branches, holds the front end during multi-cycle ALU ops and
//            counts stalled cycles.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_hazard_sequencer #(
  parameter int MUL_LATENCY = 4,   // 2..15
  parameter int CNT_W       = 16
) (
  input  wire logic                  clock,
  input  wire logic                  reset,
  pipeline_hazard_sequencer_if.slave bus
);

  localparam int         c_CountW  = 4;
  localparam logic [1:0] c_FwdReg  = 2'b00;
  localparam logic [1:0] c_FwdMem  = 2'b10;
  localparam logic [1:0] c_FwdWb   = 2'b01;
  localparam logic [c_CountW-1:0] c_MulLoad = c_CountW'(MUL_LATENCY - 1);
  localparam logic [CNT_W-1:0]    c_StallOne = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_MULDIV = 1'b1
  } stateT;

  stateT               r_state;
  stateT               w_nextState;
  logic [c_CountW-1:0] r_count;
  logic [c_CountW-1:0] w_nextCount;
  logic [CNT_W-1:0]    r_stallCycles;

  logic       w_loadUse;
  logic [1:0] w_fwdA;
  logic [1:0] w_fwdB;
  logic       w_outHazard;
  logic       w_pcWrite;
  logic       w_ifidWrite;
  logic       w_flush;
  logic       w_busy;

  // Operand forwarding: MEM result is younger than WB, so it wins; r0 never forwards
  always_comb begin
    w_fwdA = c_FwdReg;
    w_fwdB = c_FwdReg;
    if (bus.exmemRegWrite && (bus.exmemWr != 5'd0) && (bus.exmemWr == bus.idexRs))
      w_fwdA = c_FwdMem;
    else if (bus.memwbRegWrite && (bus.memwbWr != 5'd0) && (bus.memwbWr == bus.idexRs))
      w_fwdA = c_FwdWb;
    if (bus.exmemRegWrite && (bus.exmemWr != 5'd0) && (bus.exmemWr == bus.idexRt))
      w_fwdB = c_FwdMem;
    else if (bus.memwbRegWrite && (bus.memwbWr != 5'd0) && (bus.memwbWr == bus.idexRt))
      w_fwdB = c_FwdWb;
  end

  // A load in EX whose destination is read by the instruction in ID
  assign w_loadUse = bus.idexMemRead && (bus.idexRt != 5'd0) &&
                     ((bus.idexRt == bus.ifidRs) || (bus.idexRt == bus.ifidRt));

  // Next-state and same-cycle control decode
  always_comb begin
    w_nextState = r_state;
    w_nextCount = r_count;
    w_outHazard = 1'b1;
    w_pcWrite   = 1'b1;
    w_ifidWrite = 1'b1;
    w_flush     = 1'b0;
    w_busy      = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (bus.branchTaken) begin
          // Wrong-path instructions are discarded; nothing else matters this cycle
          w_flush     = 1'b1;
          w_outHazard = 1'b0;
        end else if (w_loadUse) begin
          // One bubble suffices: the load reaches MEM on the next edge
          w_pcWrite   = 1'b0;
          w_ifidWrite = 1'b0;
          w_outHazard = 1'b0;
        end else if (bus.mulStart) begin
          // Start cycle counts as the first EX cycle of the op
          w_nextCount = c_MulLoad;
          w_nextState = ST_MULDIV;
        end
      end
      ST_MULDIV: begin
        w_busy      = 1'b1;
        w_pcWrite   = 1'b0;
        w_ifidWrite = 1'b0;
        // A taken branch still flushes, but the op in EX runs to completion
        if (bus.branchTaken)
          w_flush = 1'b1;
        w_nextCount = r_count - 4'd1;
        if (r_count == 4'd1)
          w_nextState = ST_RUN;
      end
      default: begin
        w_nextState = ST_RUN;
      end
    endcase
  end

  // State and multi-cycle countdown registers
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_RUN;
      r_count <= '0;
    end else begin
      r_state <= w_nextState;
      r_count <= w_nextCount;
    end
  end

  // Saturating count of cycles in which the PC was held
  always_ff @(posedge clock) begin
    if (reset)
      r_stallCycles <= '0;
    else if (!w_pcWrite && (r_stallCycles != {CNT_W{1'b1}}))
      r_stallCycles <= r_stallCycles + c_StallOne;
  end

  assign bus.outForwardingA = w_fwdA;
  assign bus.outForwardingB = w_fwdB;
  assign bus.outHazard      = w_outHazard;
  assign bus.pcWrite        = w_pcWrite;
  assign bus.ifidWrite      = w_ifidWrite;
  assign bus.flush          = w_flush;
  assign bus.busy           = w_busy;
  assign bus.stallCycles    = r_stallCycles;

endmodule
`default_nettype wire
